// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: blanking codes, phase encoding
// and the active-high {a..g} hex glyph table.
package disp_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_DOT = 8'hFE;
  localparam logic [7:0] DIG_OFF = 8'hFF;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} phase_t;

  // {a,b,c,d,e,f,g}, 1 = segment lit
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg.sv
// Nibble to active-high {a..g} glyph; purely combinational.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NDIG digits over a shared segment bus with per-slot dead-time and a per-frame
// input snapshot; digit/segment are registered one cycle behind (cnt, slot).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 5000,
  parameter int BLANK_CYC = 250
) (
  input  logic              clk5,
  input  logic              resetn,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dots,
  input  logic [NDIG-1:0]   digit_en,
  input  logic              lz_sup,
  output logic [NDIG-1:0]   digit,
  output logic [7:0]        segment,
  output logic              frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NDIG);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C   = CW'(BLANK_CYC);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NDIG - 1);

  logic [CW-1:0]     cnt;
  logic [SW-1:0]     slot;
  logic [4*NDIG-1:0] sh_value;
  logic [NDIG-1:0]   sh_dots;
  logic [NDIG-1:0]   sh_en;
  logic              sh_lz;

  logic              snap;
  logic [4*NDIG-1:0] eff_value;
  logic [NDIG-1:0]   eff_dots;
  logic [NDIG-1:0]   eff_en;
  logic              eff_lz;
  phase_t            phase;
  logic [3:0]        nib;
  logic [6:0]        seg7;
  logic              nonzero;
  logic              suppressed;
  logic [NDIG-1:0]   nxt_digit;
  logic [7:0]        nxt_segment;

  // The snapshot edge decodes from the values being captured, so a zero-length
  // blanking window still shows the new frame's data on its first cycle.
  assign snap      = (cnt == '0) && (slot == '0);
  assign eff_value = snap ? value    : sh_value;
  assign eff_dots  = snap ? dots     : sh_dots;
  assign eff_en    = snap ? digit_en : sh_en;
  assign eff_lz    = snap ? lz_sup   : sh_lz;

  assign phase = (cnt < BLANK_C) ? BLANK : DRIVE;
  assign nib   = eff_value[4*slot +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nib),
    .seg    (seg7)
  );

  always_comb begin
    nonzero = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(slot) && eff_value[4*i +: 4] != 4'h0) nonzero = 1'b1;
    end
    suppressed  = eff_lz && (slot != '0) && !nonzero;
    nxt_digit   = '1;
    nxt_segment = SEG_OFF;
    if (phase == DRIVE) begin
      if (!suppressed) begin
        nxt_segment = {~seg7, ~eff_dots[slot]};
        if (eff_en[slot]) nxt_digit = ~(NDIG'(1) << slot);
      end else if (eff_en[slot] && eff_dots[slot]) begin
        nxt_digit   = ~(NDIG'(1) << slot);
        nxt_segment = SEG_DOT;
      end
    end
  end

  always_ff @(posedge clk5) begin
    if (!resetn) begin
      cnt        <= '0;
      slot       <= '0;
      sh_value   <= '0;
      sh_dots    <= '0;
      sh_en      <= '0;
      sh_lz      <= 1'b0;
      digit      <= '1;
      segment    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (snap) begin
        sh_value <= value;
        sh_dots  <= dots;
        sh_en    <= digit_en;
        sh_lz    <= lz_sup;
      end
      if (cnt == SCAN_LAST) begin
        cnt  <= '0;
        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      digit   <= nxt_digit;
      segment <= nxt_segment;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at NDIG=8, SCAN_DIV=10, BLANK_CYC=2 (80-cycle frame).
module tb_display_scan_ctrl;

  logic        clk5 = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dots = '0;
  logic [7:0]  digit_en = '0;
  logic        lz_sup = 1'b0;
  logic [7:0]  digit;
  logic [7:0]  segment;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  int k = 0;

  always #5 clk5 = ~clk5;

  display_scan_ctrl #(.NDIG(8), .SCAN_DIV(10), .BLANK_CYC(2)) dut (
    .clk5       (clk5),
    .resetn     (resetn),
    .value      (value),
    .dots       (dots),
    .digit_en   (digit_en),
    .lz_sup     (lz_sup),
    .digit      (digit),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dots;
    logic [7:0]  en;
    logic        lz;
    int          slot;
    logic [7:0]  dig;
    logic [7:0]  seg;
    bit          chk_seg;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  // Edge k after reset release: outputs reflect cnt=(k-1)%10, slot=(k-1)/10 (mod 8).
  task automatic tick();
    @(posedge clk5);
    #1;
    k++;
  endtask

  task automatic go_to(input int kt);
    while (k < kt) tick();
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    repeat (n) tick();
    resetn = 1'b1;
    k = 0;
  endtask

  task automatic scan_frame(input string name, input logic [7:0] may_low, input logic [7:0] dot_slots);
    int bad;
    int s;
    int c;
    bit drv;
    bad = 0;
    for (int j = 1; j <= 80; j++) begin
      tick();
      s   = (k - 1) / 10;
      c   = (k - 1) % 10;
      drv = (c >= 2);
      if ((~digit & ~may_low) != 8'h00) bad++;
      if ($countones(~digit) > 1) bad++;
      if (!drv && digit !== 8'hFF) bad++;
      if (segment[0] !== ~(drv && dot_slots[s])) bad++;
      if (frame_tick !== (k == 1)) bad++;
    end
    chk({name, "_violations"}, bad, 0);
    tick();
    chk({name, "_tick81"}, frame_tick, 1'b1);
  endtask

  initial begin
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b0, 0, 8'hFE, 8'h99, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b0, 1, 8'hFD, 8'h0D, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b0, 3, 8'hF7, 8'h9F, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b0, 4, 8'hEF, 8'h03, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b1, 3, 8'hF7, 8'h9F, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b1, 4, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h00, 8'hFF, 1'b1, 7, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{32'h0000_0000, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 8'h03, 1'b1});
    vecs.push_back('{32'h0000_0000, 8'h00, 8'hFF, 1'b1, 1, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{32'h0000_0000, 8'h10, 8'hFF, 1'b1, 4, 8'hEF, 8'hFE, 1'b1});
    vecs.push_back('{32'h0000_0100, 8'h00, 8'hFF, 1'b1, 1, 8'hFD, 8'h03, 1'b1});
    vecs.push_back('{32'h0000_0100, 8'h00, 8'hFF, 1'b1, 2, 8'hFB, 8'h9F, 1'b1});
    vecs.push_back('{32'h0000_0100, 8'h00, 8'hFF, 1'b1, 3, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h01, 8'h0F, 1'b0, 0, 8'hFE, 8'h98, 1'b1});
    vecs.push_back('{32'h0000_1234, 8'h01, 8'h0F, 1'b0, 5, 8'hFF, 8'h03, 1'b0});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 0, 8'hFE, 8'h09, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 2, 8'hFB, 8'h71, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 3, 8'hF7, 8'h61, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 4, 8'hEF, 8'h85, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 5, 8'hDF, 8'h63, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h00, 8'hFF, 1'b0, 6, 8'hBF, 8'hC1, 1'b1});
    vecs.push_back('{32'hABCD_EF09, 8'h80, 8'hFF, 1'b0, 7, 8'h7F, 8'h10, 1'b1});

    // Reset hold and first-frame timing
    value = 32'h0000_1234; dots = 8'h00; digit_en = 8'hFF; lz_sup = 1'b0;
    resetn = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rst_digit", digit, 8'hFF);
      chk("rst_segment", segment, 8'hFF);
      chk("rst_frame_tick", frame_tick, 1'b0);
    end
    resetn = 1'b1;
    k = 0;
    tick();
    chk("ft_first", frame_tick, 1'b1);
    chk("blank_k1_digit", digit, 8'hFF);
    tick();
    chk("ft_second", frame_tick, 1'b0);
    chk("blank_k2_segment", segment, 8'hFF);
    tick();
    chk("drive_k3_digit", digit, 8'hFE);
    go_to(80);
    chk("ft_k80", frame_tick, 1'b0);
    go_to(81);
    chk("ft_k81", frame_tick, 1'b1);
    go_to(161);
    chk("ft_k161", frame_tick, 1'b1);

    // Table of single-slot expectations, each from a fresh reset
    foreach (vecs[i]) begin
      value = vecs[i].value; dots = vecs[i].dots;
      digit_en = vecs[i].en; lz_sup = vecs[i].lz;
      do_reset(2);
      go_to(10 * vecs[i].slot + 1);
      chk($sformatf("vec%0d_blank_digit", i), digit, 8'hFF);
      chk($sformatf("vec%0d_blank_segment", i), segment, 8'hFF);
      go_to(10 * vecs[i].slot + 5);
      chk($sformatf("vec%0d_digit", i), digit, vecs[i].dig);
      if (vecs[i].chk_seg) chk($sformatf("vec%0d_segment", i), segment, vecs[i].seg);
    end

    // Whole-frame scans: leading-zero suppression and disabled digits with a dot
    value = 32'h0000_1234; dots = 8'h00; digit_en = 8'hFF; lz_sup = 1'b1;
    do_reset(2);
    scan_frame("lz_1234", 8'h0F, 8'h00);
    value = 32'h0000_0000;
    do_reset(2);
    scan_frame("lz_zero", 8'h01, 8'h00);
    value = 32'h0000_1234; dots = 8'h01; digit_en = 8'h0F; lz_sup = 1'b0;
    do_reset(2);
    scan_frame("en_0f_dot0", 8'h0F, 8'h01);

    // Mid-frame input change is held off until the next snapshot
    value = 32'h0000_1234; dots = 8'h00; digit_en = 8'hFF; lz_sup = 1'b0;
    do_reset(2);
    go_to(31);
    value = 32'h0000_FFFF;
    go_to(35);
    chk("snap_slot3_segment", segment, 8'h9F);
    go_to(45);
    chk("snap_slot4_segment", segment, 8'h03);
    go_to(81);
    chk("snap_next_tick", frame_tick, 1'b1);
    go_to(86);
    chk("snap_new_slot0_segment", segment, 8'h71);
    chk("snap_new_slot0_digit", digit, 8'hFE);

    // Reset pulse during slot 5 drive
    value = 32'h0000_1234;
    do_reset(2);
    go_to(55);
    chk("pre_rst_slot5_digit", digit, 8'hDF);
    resetn = 1'b0;
    tick();
    chk("midrst_digit", digit, 8'hFF);
    chk("midrst_segment", segment, 8'hFF);
    chk("midrst_frame_tick", frame_tick, 1'b0);
    resetn = 1'b1;
    k = 0;
    tick();
    chk("midrst_restart_tick", frame_tick, 1'b1);
    go_to(5);
    chk("midrst_slot0_digit", digit, 8'hFE);
    chk("midrst_slot0_segment", segment, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
